// File: rtl/amp_demodulator.sv
// AM envelope detector: full-wave rectifier, 2^LOG2_WIN boxcar moving average,
// optional 1-in-DECIM output decimation, valid/ready on both sides.
module amp_demodulator #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_WIN   = 4,
  parameter int DECIM      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] signal_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int WIN    = 1 << LOG2_WIN;
  localparam int RECT_W = DATA_WIDTH - 1;
  localparam int ACC_W  = RECT_W + LOG2_WIN;
  localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  // Magnitude of a two's-complement sample; the most-negative code saturates.
  function automatic logic [RECT_W-1:0] rectify(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] mag;
    if (x[DATA_WIDTH-1]) begin
      mag = ~x + DATA_WIDTH'(1);
    end else begin
      mag = x;
    end
    if (mag[DATA_WIDTH-1]) begin
      return {RECT_W{1'b1}};
    end else begin
      return mag[RECT_W-1:0];
    end
  endfunction

  logic                stall_s;
  logic                accept_s;
  logic                upd_s;
  logic                cnt_last_s;
  logic [ACC_W-1:0]    acc_next_s;
  logic [RECT_W-1:0]   avg_s;

  logic                s1_valid_r;
  logic [RECT_W-1:0]   rect_r;
  logic [RECT_W-1:0]   win_r [WIN];
  logic [LOG2_WIN-1:0] wptr_r;
  logic [ACC_W-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_WIDTH-1:0] signal_r;
  logic                valid_r;

  assign stall_s    = valid_r & ~ready_i;
  assign ready_o    = ~stall_s;
  assign accept_s   = valid_i & ~stall_s;
  assign upd_s      = s1_valid_r & ~stall_s;
  assign cnt_last_s = (cnt_r == CNT_LAST);
  // Sum may transiently exceed ACC_W before the oldest entry is removed; modulo wrap cancels out.
  assign acc_next_s = acc_r + ACC_W'(rect_r) - ACC_W'(win_r[wptr_r]);
  assign avg_s      = acc_next_s[ACC_W-1:LOG2_WIN];
  assign signal_o   = signal_r;
  assign valid_o    = valid_r;

  // Stage 1: rectify accepted samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      rect_r     <= '0;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        rect_r <= rectify(signal_i);
      end
    end
  end

  // Stage 2: circular window and running accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WIN; i++) begin
        win_r[i] <= '0;
      end
      wptr_r <= '0;
      acc_r  <= '0;
    end else if (upd_s) begin
      win_r[wptr_r] <= rect_r;
      wptr_r        <= wptr_r + LOG2_WIN'(1);
      acc_r         <= acc_next_s;
    end
  end

  // Decimation counter and registered output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r    <= '0;
      signal_r <= '0;
      valid_r  <= 1'b0;
    end else if (upd_s) begin
      if (cnt_last_s) begin
        cnt_r    <= '0;
        signal_r <= {1'b0, avg_s};
        valid_r  <= 1'b1;
      end else begin
        cnt_r    <= cnt_r + CNT_W'(1);
        valid_r  <= 1'b0;
      end
    end else if (!stall_s) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amp_demodulator.sv
// Self-checking bench for amp_demodulator: window-sum scoreboard model plus
// directed checks for latency, saturation, step response, stall and reset.
module tb_amp_demodulator;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        v1_i, r1_i, rdy1_o, v1_o;
  logic [15:0] s1_i, s1_o;
  logic        v4_i, r4_i, rdy4_o, v4_o;
  logic [15:0] s4_i, s4_o;

  amp_demodulator #(.DATA_WIDTH(16), .LOG2_WIN(4), .DECIM(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(v1_i), .signal_i(s1_i),
    .ready_o(rdy1_o), .signal_o(s1_o), .valid_o(v1_o), .ready_i(r1_i));

  amp_demodulator #(.DATA_WIDTH(16), .LOG2_WIN(4), .DECIM(4)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(v4_i), .signal_i(s4_i),
    .ready_o(rdy4_o), .signal_o(s4_o), .valid_o(v4_o), .ready_i(r4_i));

  int tests = 0;
  int fails = 0;

  function automatic int rect_ref(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard models: last-16 window recomputed by summation on each accept.
  int win1[16], pos1, cnt1, exp1_q[$];
  int win4[16], pos4, cnt4, exp4_q[$], xfer4;

  always @(negedge clk_i) begin
    int e, sum;
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin win1[i] = 0; win4[i] = 0; end
      pos1 = 0; cnt1 = 0; pos4 = 0; cnt4 = 0; xfer4 = 0;
      exp1_q.delete(); exp4_q.delete();
    end else begin
      if (v1_o && r1_i) begin
        tests++;
        assert (exp1_q.size() != 0) else begin
          fails++; $error("FAIL sb1_extra observed=%0d expected=none", s1_o);
        end
        if (exp1_q.size() != 0) begin
          e = exp1_q.pop_front();
          check("sb1_value", 32'(s1_o), 32'(e));
        end
      end
      if (v4_o && r4_i) begin
        xfer4++;
        tests++;
        assert (exp4_q.size() != 0) else begin
          fails++; $error("FAIL sb4_extra observed=%0d expected=none", s4_o);
        end
        if (exp4_q.size() != 0) begin
          e = exp4_q.pop_front();
          check("sb4_value", 32'(s4_o), 32'(e));
        end
      end
      if (v1_i && rdy1_o) begin
        win1[pos1] = rect_ref(s1_i);
        pos1 = (pos1 + 1) % 16;
        sum = 0;
        for (int i = 0; i < 16; i++) sum += win1[i];
        exp1_q.push_back(sum / 16);
      end
      if (v4_i && rdy4_o) begin
        win4[pos4] = rect_ref(s4_i);
        pos4 = (pos4 + 1) % 16;
        cnt4++;
        if (cnt4 == 4) begin
          cnt4 = 0;
          sum = 0;
          for (int i = 0; i < 16; i++) sum += win4[i];
          exp4_q.push_back(sum / 16);
        end
      end
    end
  end

  bit sign1 = 1'b0;
  bit sign4 = 1'b0;

  task automatic feed1(input int n, input int amp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      v1_i  = 1'b1;
      sign1 = ~sign1;
      s1_i  = sign1 ? 16'(-amp) : 16'(amp);
    end
  endtask

  task automatic idle1(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      v1_i = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic first_out(input string tag);
    @(posedge clk_i); #1; v1_i = 1'b1; s1_i = 16'd1000;
    @(negedge clk_i); check({tag, "_valid_before"}, 32'(v1_o), 32'd0);
    @(posedge clk_i); #1; s1_i = 16'hFC18;
    @(negedge clk_i); check({tag, "_valid_c1"}, 32'(v1_o), 32'd0);
    @(posedge clk_i); #1; s1_i = 16'd1000;
    @(negedge clk_i);
    check({tag, "_valid_c2"}, 32'(v1_o), 32'd1);
    check({tag, "_first_62"}, 32'(s1_o), 32'd62);
  endtask

  initial begin
    int n4;
    v1_i = 1'b0; s1_i = '0; r1_i = 1'b1;
    v4_i = 1'b0; s4_i = '0; r4_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 32'(v1_o), 32'd0);
    check("rst_signal", 32'(s1_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_ready", 32'(rdy1_o), 32'd1);

    // Warm-up ramp then steady 1000
    first_out("ramp");
    feed1(29, 1000);
    idle1(3);
    check("ramp_steady", 32'(s1_o), 32'd1000);
    check("ramp_idle_valid", 32'(v1_o), 32'd0);

    // Envelope step 1000 -> 200
    feed1(1, 200);
    idle1(3);
    check("step_first", 32'(s1_o), 32'd950);
    feed1(14, 200);
    idle1(3);
    check("step_15", 32'(s1_o), 32'd250);
    feed1(1, 200);
    idle1(3);
    check("step_settled", 32'(s1_o), 32'd200);

    // Backpressure mid-stream
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      v1_i  = 1'b1;
      sign1 = ~sign1;
      s1_i  = sign1 ? 16'(-600) : 16'(600);
      r1_i  = !(i >= 8 && i < 13);
      if (!r1_i) begin
        @(negedge clk_i);
        check("stall_ready", 32'(rdy1_o), 32'd0);
        check("stall_valid", 32'(v1_o), 32'd1);
        if (exp1_q.size() != 0) check("stall_hold", 32'(s1_o), 32'(exp1_q[0]));
      end
    end
    @(posedge clk_i); #1; r1_i = 1'b1;
    idle1(4);
    check("stall_drained", 32'(exp1_q.size()), 32'd0);

    // Saturation on most-negative input
    feed1(20, -32768);
    idle1(3);
    check("sat_value", 32'(s1_o), 32'd32767);
    check("sat_sign", 32'(s1_o[15]), 32'd0);

    // Decimation by 4 with input bubbles
    n4 = 0;
    for (int i = 0; i < 200 || (n4 % 4) != 0; i++) begin
      @(posedge clk_i); #1;
      v4_i  = (i >= 200) ? 1'b1 : ($urandom_range(99) >= 30);
      sign4 = ~sign4;
      s4_i  = sign4 ? 16'(-800) : 16'(800);
      if (v4_i) n4++;
    end
    @(posedge clk_i); #1; v4_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("decim_count", 32'(xfer4), 32'(n4 / 4));
    check("decim_steady", 32'(s4_o), 32'd800);
    check("decim_drained", 32'(exp4_q.size()), 32'd0);

    // Asynchronous reset mid-ramp
    feed1(40, 1000);
    feed1(5, 300);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(v1_o), 32'd0);
    check("arst_signal", 32'(s1_o), 32'd0);
    check("arst_signal4", 32'(s4_o), 32'd0);
    v1_i = 1'b0;
    @(negedge clk_i); #2;
    rst_ni = 1'b1;
    first_out("arst");
    feed1(6, 1000);
    idle1(3);
    check("arst_ramp", 32'(s1_o), 32'd562);
    check("arst_drained", 32'(exp1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
